// File: rtl/ram_n2t_pkg.sv
// Shared Hack-machine word constants for the RAM building blocks.
// Combinational definitions only; no state, no latency, no flow control.
// Optional build macro used by ram_n2t: RAM_BYPASS_EN.
package n2t_pkg;

    localparam int N2T_WORD_W     = 16;
    localparam int N2T_RAM8_DEPTH = 8;

    typedef logic [N2T_WORD_W-1:0] hack_word_t;

endpackage

// File: rtl/reg_n2t.sv
// Single load register of WIDTH bits with synchronous active-low clear.
// Latency: written value visible on out one rising edge after load.
// Backpressure: none; load is accepted unconditionally every cycle.
module reg_n2t #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: rtl/ram_n2t.sv
// Word-addressable RAM of DEPTH load registers; addr_err flags out-of-range writes.
// Latency: 0-cycle combinational read, 1-cycle write; RAM_BYPASS_EN gives write-first read.
// Backpressure: none; one read and one write per cycle always accepted.
module ram_n2t
    import n2t_pkg::*;
#(
    parameter int WIDTH = N2T_WORD_W,
    parameter int DEPTH = N2T_RAM8_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic [$clog2(DEPTH)-1:0] address,
    output logic [WIDTH-1:0]         out,
    output logic                     addr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic                        in_range;
    logic [DEPTH-1:0]            word_load;
    logic [DEPTH-1:0][WIDTH-1:0] word_dat;
    logic [WIDTH-1:0]            rd_dat;
    logic                        addr_err_d;
    logic                        addr_err_q;

    // Only reachable when DEPTH is not a power of two.
    assign in_range = ({1'b0, address} < DEPTH_W);

    always_comb begin
        word_load = '0;
        rd_dat    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == AW'(i)) begin
                word_load[i] = load && in_range;
                rd_dat       = word_dat[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_word
            reg_n2t #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .in    (in),
                .load  (word_load[g]),
                .out   (word_dat[g])
            );
        end
    endgenerate

    always_comb begin
        addr_err_d = addr_err_q;
        if (load) begin
            addr_err_d = !in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err = addr_err_q;

`ifdef RAM_BYPASS_EN
    // Write-first: pending in-range write data wins over stored word.
    assign out = (reset && load && in_range) ? in : rd_dat;
`else
    assign out = rd_dat;
`endif

endmodule
